// File: rtl/adc_serial_responder.sv
`default_nettype none
// ============================================================================
//  Module      : adc_serial_responder
//  Description : Far-end responder for the 8-channel 12-bit serial ADC link.
//                Oversamples SCLK/CS/DIN on adc_clk and returns one 16-bit
//                frame per CS assertion. Optional build macro ADC_TESTPAT_EN
//                replaces sample_in with internal per-channel ramps.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_serial_responder #(
    parameter int DATA_W      = 12,
    parameter int LEAD_W      = 3,
    parameter int FRAME_W     = 16,
    parameter int CH_W        = 3,
    parameter int ADDR_POS    = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic              adc_clk,
    input  logic              rst_l,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              din,
    output logic              dout,
    output logic              dout_oe,
    output logic [CH_W-1:0]   ch_sel,
    input  logic [DATA_W-1:0] sample_in,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] c_frame_cnt = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    // CS chain resets high so a released reset never looks like a CS fall.
    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic w_sclk_s;
    logic w_cs_s;
    logic w_din_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;

    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign w_din_s     = din_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk_s & sclk_prev_q;
    assign w_cs_fall   = cs_prev_q & ~w_cs_s;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]  shift_q,   shift_d;
    logic [FRAME_W-1:0]  ctrl_q,    ctrl_d;
    logic                dout_q,    dout_d;
    logic                oe_q,      oe_d;
    logic [CH_W-1:0]     ch_sel_q,  ch_sel_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;

    logic [DATA_W-1:0]   w_load_val;
    logic [FRAME_W-1:0]  w_load_frame;

`ifdef ADC_TESTPAT_EN
    // ------------------------------------------------------------------
    // Test pattern: per-channel 9-bit ramps tagged with the channel number
    // ------------------------------------------------------------------
    localparam int RAMP_W = DATA_W - CH_W;
    localparam int NUM_CH = 1 << CH_W;

    logic [RAMP_W-1:0] ramp_q [NUM_CH];
    logic [CH_W-1:0]   load_ch_q;

    // The ramp that advances is the one whose value went out in this frame.
    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ramp_q[i] <= '0;
            end
            load_ch_q <= '0;
        end else begin
            if (state_q == ST_IDLE && w_cs_fall) begin
                load_ch_q <= ch_sel_q;
            end
            if (done_q) begin
                ramp_q[load_ch_q] <= ramp_q[load_ch_q] + RAMP_W'(1);
            end
        end
    end

    assign w_load_val = {ch_sel_q, ramp_q[ch_sel_q]};
`else
    assign w_load_val = sample_in;
`endif

    assign w_load_frame = {{LEAD_W{1'b0}}, w_load_val, 1'b0};

    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ctrl_q    <= '0;
            dout_q    <= 1'b0;
            oe_q      <= 1'b0;
            ch_sel_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ctrl_q    <= ctrl_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            ch_sel_q  <= ch_sel_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ctrl_d    = ctrl_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        ch_sel_d  = ch_sel_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                oe_d   = 1'b0;
                dout_d = 1'b0;
                // A simultaneous SCLK edge is deliberately not examined here.
                if (w_cs_fall) begin
                    shift_d   = w_load_frame;
                    ctrl_d    = '0;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
                    dout_d    = w_load_frame[FRAME_W-1];
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_cs_s) begin
                    oe_d    = 1'b0;
                    dout_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_sclk_rise) begin
                    ctrl_d = {ctrl_q[FRAME_W-2:0], w_din_s};
                    if (bit_cnt_q != c_frame_cnt) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (bit_cnt_q == c_last_bit) begin
                        ch_sel_d = ctrl_d[ADDR_POS -: CH_W];
                        done_d   = 1'b1;
                        oe_d     = 1'b0;
                        dout_d   = 1'b0;
                        state_d  = ST_DONE;
                    end
                end else if (w_sclk_fall) begin
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    // The fall that would present bit 0 releases the line instead.
                    if (bit_cnt_q == c_last_bit) begin
                        oe_d   = 1'b0;
                        dout_d = 1'b0;
                    end else begin
                        dout_d = shift_q[FRAME_W-2];
                    end
                end
            end

            ST_DONE: begin
                oe_d   = 1'b0;
                dout_d = 1'b0;
                if (w_cs_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_oe    = oe_q;
    assign ch_sel     = ch_sel_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_serial_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_serial_responder
//  Description : Self-checking bench for adc_serial_responder (table frames,
//                scoreboard queue, hand-written corner sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_serial_responder;

    logic        adc_clk = 1'b0;
    logic        rst_l   = 1'b0;
    logic        sclk    = 1'b0;
    logic        cs_n    = 1'b1;
    logic        din     = 1'b0;
    logic        dout;
    logic        dout_oe;
    logic [2:0]  ch_sel;
    logic [11:0] sample_in;
    logic        frame_done;
    logic        frame_err;

    logic [11:0] chan_val [8];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    typedef struct {
        logic [15:0] ctrl;
        logic [11:0] exp_sample;
        logic [2:0]  exp_ch;
    } vec_t;

    typedef struct {
        logic [11:0] samp;
        logic [2:0]  ch;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    adc_serial_responder dut (
        .adc_clk    (adc_clk),
        .rst_l      (rst_l),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .din        (din),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .ch_sel     (ch_sel),
        .sample_in  (sample_in),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 adc_clk = ~adc_clk;

    assign sample_in = chan_val[ch_sel];

    always @(negedge adc_clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1)  err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge adc_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // One full master frame at SCLK = adc_clk/8, mode 0, sampling dout before each rise.
    task automatic run_frame(input logic [15:0] ctrl, input logic [11:0] esamp,
                             input logic [2:0] ech, input int extra, input string tag);
        logic [15:0] got_d;
        logic [15:0] got_oe;
        logic        extra_oe;
        int          d0;
        int          e0;
        exp_t        e;
        d0 = done_cnt;
        e0 = err_cnt;
        sb.push_back('{samp: esamp, ch: ech});
        din  = ctrl[15];
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 16; i++) begin
            got_d[15-i]  = dout;
            got_oe[15-i] = dout_oe;
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
            if (i < 15) din = ctrl[14-i];
            cyc(4);
        end
        extra_oe = 1'b0;
        for (int i = 0; i < extra; i++) begin
            sclk = 1'b1;
            cyc(4);
            extra_oe = extra_oe | dout_oe;
            sclk = 1'b0;
            cyc(4);
            extra_oe = extra_oe | dout_oe;
        end
        cs_n = 1'b1;
        din  = 1'b0;
        cyc(4);
        e = sb.pop_front();
        check({tag, " data"}, {17'd0, got_d[15:1]}, {17'd0, 3'b000, e.samp});
        check({tag, " oe"}, {16'd0, got_oe}, 32'h0000_FFFE);
        check({tag, " done_pulses"}, done_cnt - d0, 1);
        check({tag, " err_pulses"}, err_cnt - e0, 0);
        check({tag, " ch_sel"}, {29'd0, ch_sel}, {29'd0, e.ch});
        if (extra > 0) check({tag, " extra_edges_oe"}, {31'd0, extra_oe}, 0);
    endtask

    initial begin : main
        logic any_oe;
        logic any_dout;
        int   d0;
        int   e0;

        chan_val[0] = 12'hA5C; chan_val[1] = 12'h1B1;
        chan_val[2] = 12'h2C2; chan_val[3] = 12'h3D3;
        chan_val[4] = 12'h4E4; chan_val[5] = 12'h5F5;
        chan_val[6] = 12'h606; chan_val[7] = 12'h717;

        vecs[0]  = '{16'h0000, 12'hA5C, 3'd0};
        vecs[1]  = '{16'h2800, 12'hA5C, 3'd5};
        vecs[2]  = '{16'h07FF, 12'h5F5, 3'd0};
        vecs[3]  = '{16'hC000, 12'hA5C, 3'd0};
        vecs[4]  = '{16'h0800, 12'hA5C, 3'd1};
        vecs[5]  = '{16'h1000, 12'h1B1, 3'd2};
        vecs[6]  = '{16'h1800, 12'h2C2, 3'd3};
        vecs[7]  = '{16'h2000, 12'h3D3, 3'd4};
        vecs[8]  = '{16'h2800, 12'h4E4, 3'd5};
        vecs[9]  = '{16'h3155, 12'h5F5, 3'd6};
        vecs[10] = '{16'h3800, 12'h606, 3'd7};
        vecs[11] = '{16'h1AAA, 12'h717, 3'd3};

        // Reset held while the master wiggles every line
        rst_l    = 1'b0;
        any_oe   = 1'b0;
        any_dout = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sclk = ~sclk;
            cs_n = i[1];
            din  = i[0];
            cyc(2);
            any_oe   = any_oe | dout_oe;
            any_dout = any_dout | dout;
        end
        check("reset oe", {31'd0, any_oe}, 0);
        check("reset dout", {31'd0, any_dout}, 0);
        check("reset ch_sel", {29'd0, ch_sel}, 0);
        check("reset done", done_cnt, 0);
        check("reset err", err_cnt, 0);
        sclk = 1'b0;
        cs_n = 1'b1;
        din  = 1'b0;
        cyc(2);
        rst_l = 1'b1;
        cyc(4);

`ifdef ADC_TESTPAT_EN
        run_frame(16'h1000, 12'h000, 3'd2, 0, "tp_prime");
        run_frame(16'h1000, 12'h400, 3'd2, 0, "tp_0");
        run_frame(16'h1000, 12'h401, 3'd2, 0, "tp_1");
        run_frame(16'h1000, 12'h402, 3'd2, 0, "tp_2");
`else
        for (int v = 0; v < 12; v++) begin
            run_frame(vecs[v].ctrl, vecs[v].exp_sample, vecs[v].exp_ch, 0, $sformatf("vec%0d", v));
        end

        // Abort after 7 SCLKs
        d0 = done_cnt;
        e0 = err_cnt;
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 7; i++) begin
            sclk = 1'b1; cyc(4);
            sclk = 1'b0; cyc(4);
        end
        check("abort oe_mid", {31'd0, dout_oe}, 1);
        cs_n = 1'b1;
        cyc(4);
        check("abort err_pulse", err_cnt - e0, 1);
        check("abort oe", {31'd0, dout_oe}, 0);
        check("abort ch_sel", {29'd0, ch_sel}, 3);
        check("abort done", done_cnt - d0, 0);
        run_frame(16'h1800, 12'h3D3, 3'd3, 0, "post_abort");

        // Extra SCLK edges while waiting for CS to rise
        run_frame(16'h2000, 12'h3D3, 3'd4, 2, "done_extra");

        // SCLK activity with CS idle
        d0 = done_cnt;
        e0 = err_cnt;
        any_oe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1; cyc(3); any_oe = any_oe | dout_oe;
            sclk = 1'b0; cyc(3); any_oe = any_oe | dout_oe;
        end
        check("idle_edges oe", {31'd0, any_oe}, 0);
        check("idle_edges done", done_cnt - d0, 0);
        check("idle_edges err", err_cnt - e0, 0);
        check("idle_edges ch_sel", {29'd0, ch_sel}, 4);

        // CS fall and SCLK rise together: the rise must not be counted
        d0 = done_cnt;
        din  = 1'b0;
        cs_n = 1'b0;
        sclk = 1'b1;
        cyc(4);
        check("collide oe", {31'd0, dout_oe}, 1);
        sclk = 1'b0;
        cyc(4);
        for (int i = 0; i < 15; i++) begin
            sclk = 1'b1; cyc(4);
            sclk = 1'b0; cyc(4);
        end
        check("collide early_done", done_cnt - d0, 0);
        sclk = 1'b1;
        cyc(4);
        check("collide done", done_cnt - d0, 1);
        sclk = 1'b0;
        cyc(4);
        cs_n = 1'b1;
        cyc(4);
        check("collide ch_sel", {29'd0, ch_sel}, 0);

        // Reset in the middle of a frame
        run_frame(16'h3000, 12'hA5C, 3'd6, 0, "pre_rst");
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; cyc(4);
            sclk = 1'b0; cyc(4);
        end
        check("midrst oe_before", {31'd0, dout_oe}, 1);
        rst_l = 1'b0;
        #1;
        check("midrst oe", {31'd0, dout_oe}, 0);
        check("midrst ch_sel", {29'd0, ch_sel}, 0);
        check("midrst dout", {31'd0, dout}, 0);
        cs_n = 1'b1;
        cyc(3);
        rst_l = 1'b1;
        cyc(4);
        run_frame(16'h0000, 12'hA5C, 3'd0, 0, "post_rst");
`endif

        check("scoreboard empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
